// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared constants and state encoding for the instruction fetch stage
package instruction_fetch_pkg;

   // PC loaded on reset unless the instance overrides it
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // opcode field bounds inside an instruction word
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;

   // value placed in IF/ID when it holds no real instruction
   localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

   // REQ: request outstanding, HOLD: word buffered while decode stalls,
   // DRAIN: waiting for a response that a redirect made stale
   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

   // word-addressed PC step, wraps naturally at 2^32
   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + 32'd1;
   endfunction

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, memory request, one-entry hold buffer and IF/ID register
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic        if_id_valid,
   output logic [5:0]  opcode
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  req_addr;
   logic         req_q;
   logic [31:0]  buf_instr;
   logic         done;

   // a response only counts while a request is actually being driven
   assign done      = req_q & imem_ready;
   assign imem_req  = req_q;
   assign imem_addr = req_addr;
   assign opcode    = if_id_instr[OPCODE_MSB:OPCODE_LSB];

   // fetch FSM with PC, request address, hold buffer and IF/ID registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_REQ;
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         req_q       <= 1'b0;
         buf_instr   <= BUBBLE_INSTR;
         if_id_instr <= BUBBLE_INSTR;
         if_id_pc    <= 32'd0;
         if_id_valid <= 1'b0;
      end else if (redirect) begin
         pc          <= redirect_pc;
         if_id_valid <= 1'b0;
         if_id_instr <= BUBBLE_INSTR;
         buf_instr   <= BUBBLE_INSTR;
         req_q       <= 1'b1;
         if (state != ST_HOLD && req_q && !imem_ready) begin
            // the old request is still in flight: keep its address and swallow its response
            state <= ST_DRAIN;
         end else begin
            state    <= ST_REQ;
            req_addr <= redirect_pc;
         end
      end else begin
         case (state)
            ST_REQ: begin
               if (done && stall) begin
                  buf_instr <= imem_rdata;
                  req_q     <= 1'b0;
                  state     <= ST_HOLD;
               end else if (done) begin
                  if_id_instr <= imem_rdata;
                  if_id_pc    <= pc_next(pc);
                  if_id_valid <= 1'b1;
                  pc          <= pc_next(pc);
                  req_addr    <= pc_next(pc);
                  req_q       <= 1'b1;
               end else begin
                  req_q <= 1'b1;
                  if (!stall) begin
                     if_id_valid <= 1'b0;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  if_id_instr <= buf_instr;
                  if_id_pc    <= pc_next(pc);
                  if_id_valid <= 1'b1;
                  pc          <= pc_next(pc);
                  req_addr    <= pc_next(pc);
                  req_q       <= 1'b1;
                  state       <= ST_REQ;
               end
            end
            ST_DRAIN: begin
               req_q <= 1'b1;
               if (done) begin
                  req_addr <= pc;
                  state    <= ST_REQ;
               end
            end
            default: begin
               state <= ST_REQ;
               req_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'd0;
   logic        imem_ready = 1'b0;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic        if_id_valid;
   logic [5:0]  opcode;

   int tests_run = 0;
   int tests_failed = 0;

   // stimulus controls
   logic        rst_i, stall_i, redir_i;
   logic [31:0] rpc_i;
   int          lat_mode = 0;
   int          lat_left = 0;
   logic        scramble = 1'b0;

   // reference model state
   logic [31:0] m_pc, m_addr, m_word, m_instr, m_ifpc;
   logic        m_req, m_discard, m_held, m_valid;

   instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .opcode(opcode)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (scramble) return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      return a + 32'h100;
   endfunction

   function automatic int pick_lat();
      if (lat_mode < 0) return int'($urandom_range(3, 0));
      return lat_mode;
   endfunction

   task automatic deliver(input logic [31:0] w);
      m_instr = w;
      m_ifpc  = m_pc + 32'd1;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd1;
      m_addr  = m_pc;
   endtask

   // one clock: memory answers the visible request, inputs applied, model advanced
   task automatic step();
      logic take;
      if (imem_req && lat_left == 0) begin
         imem_ready = 1'b1;
         imem_rdata = memf(imem_addr);
         lat_left   = pick_lat();
      end else if (imem_req) begin
         imem_ready = 1'b0;
         imem_rdata = $urandom;
         lat_left   = lat_left - 1;
      end else begin
         imem_ready = 1'($urandom_range(1, 0));
         imem_rdata = $urandom;
      end
      if (rst_i) lat_left = pick_lat();
      rst = rst_i; stall = stall_i; redirect = redir_i; redirect_pc = rpc_i;
      if (rst_i) begin
         m_pc = 32'd0; m_addr = 32'd0; m_req = 1'b0; m_discard = 1'b0; m_held = 1'b0;
         m_word = 32'd0; m_instr = 32'd0; m_ifpc = 32'd0; m_valid = 1'b0;
      end else begin
         take = m_req && imem_ready;
         if (redir_i) begin
            m_pc = rpc_i; m_valid = 1'b0; m_instr = 32'd0;
            if (m_req && !imem_ready && !m_held) m_discard = 1'b1;
            else begin m_discard = 1'b0; m_addr = rpc_i; end
            m_held = 1'b0; m_req = 1'b1;
         end else if (m_held) begin
            if (!stall_i) begin deliver(m_word); m_held = 1'b0; m_req = 1'b1; end
         end else if (m_discard) begin
            m_req = 1'b1;
            if (take) begin m_discard = 1'b0; m_addr = m_pc; end
         end else begin
            m_req = 1'b1;
            if (take && stall_i) begin m_held = 1'b1; m_word = imem_rdata; m_req = 1'b0; end
            else if (take) deliver(imem_rdata);
            else if (!stall_i) m_valid = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_i = 1'b1; stall_i = 1'b0; redir_i = 1'b0; rpc_i = 32'd0;
      step(); step();
      rst_i = 1'b0;
      step();
   endtask

   task automatic test_reset();
      lat_mode = 0; scramble = 1'b0;
      rst_i = 1'b1; stall_i = 1'b0; redir_i = 1'b0; rpc_i = 32'd0;
      step(); step();
      tests_run++;
      if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || if_id_pc !== 32'd0 || opcode !== 6'd0) begin
         tests_failed++;
         $display("FAIL reset_state req=%b valid=%b instr=%h pc=%h op=%h expected all zero",
                  imem_req, if_id_valid, if_id_instr, if_id_pc, opcode);
      end
      rst_i = 1'b0;
      step();
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
         tests_failed++;
         $display("FAIL first_request req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
      end
   endtask

   task automatic test_stream();
      lat_mode = 0; scramble = 1'b0;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         step();
         tests_run++;
         if (if_id_valid !== 1'b1 || if_id_instr !== 32'h100 + 32'(k) || if_id_pc !== 32'(k + 1)) begin
            tests_failed++;
            $display("FAIL stream[%0d] valid=%b instr=%h pc=%h expected valid=1 instr=%h pc=%h",
                     k, if_id_valid, if_id_instr, if_id_pc, 32'h100 + 32'(k), 32'(k + 1));
         end
      end
   endtask

   task automatic test_latency();
      logic [31:0] addr_seen [3];
      logic        valid_seen [3];
      lat_mode = 2; scramble = 1'b0;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         addr_seen[k] = imem_addr;
         step();
         valid_seen[k] = if_id_valid;
      end
      tests_run++;
      if (addr_seen[0] !== 32'd0 || addr_seen[1] !== 32'd0 || addr_seen[2] !== 32'd0) begin
         tests_failed++;
         $display("FAIL latency_addr got %h %h %h expected 0 0 0", addr_seen[0], addr_seen[1], addr_seen[2]);
      end
      tests_run++;
      if (valid_seen[0] !== 1'b0 || valid_seen[1] !== 1'b0 || valid_seen[2] !== 1'b1 || if_id_instr !== 32'h100) begin
         tests_failed++;
         $display("FAIL latency_valid got %b%b%b instr=%h expected 001 instr=00000100",
                  valid_seen[0], valid_seen[1], valid_seen[2], if_id_instr);
      end
   endtask

   task automatic test_stall_hold();
      lat_mode = 0; scramble = 1'b0;
      do_reset();
      step();
      stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         tests_run++;
         if (imem_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_instr !== 32'h100 || if_id_pc !== 32'd1) begin
            tests_failed++;
            $display("FAIL hold[%0d] req=%b valid=%b instr=%h pc=%h expected req=0 valid=1 instr=00000100 pc=1",
                     k, imem_req, if_id_valid, if_id_instr, if_id_pc);
         end
      end
      stall_i = 1'b0;
      step();
      tests_run++;
      if (if_id_valid !== 1'b1 || if_id_instr !== 32'h101 || if_id_pc !== 32'd2 || imem_req !== 1'b1 || imem_addr !== 32'd2) begin
         tests_failed++;
         $display("FAIL hold_release valid=%b instr=%h pc=%h req=%b addr=%h expected 1 00000101 2 1 2",
                  if_id_valid, if_id_instr, if_id_pc, imem_req, imem_addr);
      end
      step();
      tests_run++;
      if (if_id_valid !== 1'b1 || if_id_instr !== 32'h102 || if_id_pc !== 32'd3) begin
         tests_failed++;
         $display("FAIL hold_next valid=%b instr=%h pc=%h expected 1 00000102 3", if_id_valid, if_id_instr, if_id_pc);
      end
   endtask

   task automatic test_redirect_drain();
      int n;
      lat_mode = 0; scramble = 1'b0;
      do_reset();
      for (int k = 0; k < 5; k++) step();
      lat_left = 3;
      redir_i = 1'b1; rpc_i = 32'h40;
      step();
      redir_i = 1'b0;
      n = 0;
      while (imem_addr === 32'h5 && n < 10) begin
         tests_run++;
         if (if_id_valid !== 1'b0 || imem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain[%0d] valid=%b req=%b expected valid=0 req=1", n, if_id_valid, imem_req);
         end
         step();
         n++;
      end
      tests_run++;
      if (imem_addr !== 32'h40 || if_id_valid !== 1'b0 || n < 2) begin
         tests_failed++;
         $display("FAIL drain_exit addr=%h valid=%b cycles=%0d expected addr=00000040 valid=0 cycles>=2",
                  imem_addr, if_id_valid, n);
      end
      step();
      tests_run++;
      if (if_id_valid !== 1'b1 || if_id_instr !== 32'h140 || if_id_pc !== 32'h41) begin
         tests_failed++;
         $display("FAIL drain_target valid=%b instr=%h pc=%h expected 1 00000140 00000041",
                  if_id_valid, if_id_instr, if_id_pc);
      end
   endtask

   task automatic test_redirect_stall();
      lat_mode = 0; scramble = 1'b0;
      do_reset();
      step();
      redir_i = 1'b1; stall_i = 1'b1; rpc_i = 32'h80;
      step();
      redir_i = 1'b0; stall_i = 1'b0;
      tests_run++;
      if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || opcode !== 6'd0 || imem_addr !== 32'h80) begin
         tests_failed++;
         $display("FAIL redirect_stall valid=%b instr=%h op=%h addr=%h expected 0 00000000 00 00000080",
                  if_id_valid, if_id_instr, opcode, imem_addr);
      end
      step();
      tests_run++;
      if (if_id_valid !== 1'b1 || if_id_instr !== 32'h180 || if_id_pc !== 32'h81) begin
         tests_failed++;
         $display("FAIL redirect_stall_next valid=%b instr=%h pc=%h expected 1 00000180 00000081",
                  if_id_valid, if_id_instr, if_id_pc);
      end
   endtask

   task automatic test_wrap();
      lat_mode = 0; scramble = 1'b0;
      do_reset();
      redir_i = 1'b1; rpc_i = 32'hFFFF_FFFF;
      step();
      redir_i = 1'b0;
      step();
      tests_run++;
      if (if_id_valid !== 1'b1 || if_id_instr !== 32'h0000_00FF || if_id_pc !== 32'd0 || imem_addr !== 32'd0) begin
         tests_failed++;
         $display("FAIL wrap valid=%b instr=%h pc=%h addr=%h expected 1 000000ff 00000000 00000000",
                  if_id_valid, if_id_instr, if_id_pc, imem_addr);
      end
      stall_i = 1'b1;
      step();
      stall_i = 1'b0;
      tests_run++;
      if (imem_req !== 1'b0 || if_id_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_hold req=%b valid=%b expected req=0 valid=1", imem_req, if_id_valid);
      end
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      tests_run++;
      if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || if_id_pc !== 32'd0 || opcode !== 6'd0) begin
         tests_failed++;
         $display("FAIL reset_in_hold req=%b valid=%b instr=%h pc=%h op=%h expected all zero",
                  imem_req, if_id_valid, if_id_instr, if_id_pc, opcode);
      end
   endtask

   task automatic test_random();
      lat_mode = -1; scramble = 1'b1;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst_i   = ($urandom_range(99, 0) == 0);
         stall_i = ($urandom_range(9, 0) < 3);
         redir_i = ($urandom_range(99, 0) < 8);
         rpc_i   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(1, 0))) : $urandom;
         step();
         tests_run++;
         if (imem_req !== m_req || imem_addr !== m_addr || if_id_valid !== m_valid ||
             if_id_instr !== m_instr || if_id_pc !== m_ifpc || opcode !== m_instr[31:26]) begin
            tests_failed++;
            $display("FAIL random[%0d] req=%b addr=%h valid=%b instr=%h pc=%h op=%h expected %b %h %b %h %h %h",
                     c, imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc, opcode,
                     m_req, m_addr, m_valid, m_instr, m_ifpc, m_instr[31:26]);
         end
         if (if_id_valid === 1'b1) begin
            tests_run++;
            if (if_id_instr !== memf(if_id_pc - 32'd1)) begin
               tests_failed++;
               $display("FAIL random_word[%0d] instr=%h expected %h for pc=%h",
                        c, if_id_instr, memf(if_id_pc - 32'd1), if_id_pc);
            end
         end
      end
   endtask

   initial begin
      rst_i = 1'b1; stall_i = 1'b0; redir_i = 1'b0; rpc_i = 32'd0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_latency();
      test_stall_hold();
      test_redirect_drain();
      test_redirect_stall();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
